// File: rtl/i2s_sample_bridge_pkg.sv
// i2s_pkg: shared constants for the I2S sample bridge.
//   PDATA_WIDTH_DEFAULT : default width of one channel sample
//   CNT_W               : width of the RX capture delay counter
package i2s_pkg;

  localparam int unsigned PDATA_WIDTH_DEFAULT = 32;
  localparam int unsigned CNT_W               = 4;

endpackage

// File: rtl/i2s_sample_bridge_fifo.sv
// sample_fifo: show-ahead FIFO holding received stereo frames.
//   i_clk, i_rst : clock, asynchronous active-high reset (flushes contents)
//   i_push/i_data: write request and data; ignored when full unless popping
//   i_pop        : read request; ignored when empty
//   o_data       : current head entry (valid while ~o_empty)
//   o_full/o_empty: occupancy flags
module sample_fifo
  import i2s_pkg::*;
#(
  parameter int unsigned WIDTH = 2 * PDATA_WIDTH_DEFAULT,
  parameter int unsigned DEPTH = 4
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_data,
  output logic             o_full,
  output logic             o_empty
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW:0]      r_wr_ptr;
  logic [AW:0]      r_rd_ptr;
  logic             w_do_push;
  logic             w_do_pop;

  // Extra pointer MSB distinguishes full from empty when the indices match.
  assign o_empty = (r_wr_ptr == r_rd_ptr);
  assign o_full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                   (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);

  // When full, a simultaneous pop frees the head slot, which is also the write slot.
  assign w_do_push = i_push & (~o_full | i_pop);
  assign w_do_pop  = i_pop & ~o_empty;

  assign o_data = r_mem[r_rd_ptr[AW-1:0]];

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
    end else begin
      if (w_do_push) begin
        r_mem[r_wr_ptr[AW-1:0]] <= i_data;
        r_wr_ptr                <= r_wr_ptr + 1'b1;
      end
      if (w_do_pop) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
    end
  end

endmodule

// File: rtl/i2s_sample_bridge.sv
// i2s_sample_bridge: frame-synchronous bridge between an I2S transceiver's
// parallel sample ports and a DSP core, all in the mclk_in domain.
//   mclk_in, arst_in          : clock, asynchronous active-high reset
//   lrck_in                   : word clock; its falling edge marks a frame
//   pldata_in, prdata_in      : received left/right samples
//   rx_valid/ready, rx_*data  : RX stream (show-ahead FIFO head)
//   tx_valid/ready, tx_*data  : TX stream into a one-entry holding register
//   pldata_out, prdata_out    : samples driven to the transceiver once per frame
//   frame_out                 : one-cycle pulse per detected LRCK falling edge
//   clear_in                  : clears the sticky flags
//   rx_overflow_out           : sticky, an RX frame was dropped
//   tx_underflow_out          : sticky, a frame passed with no TX sample held
module i2s_sample_bridge
  import i2s_pkg::*;
#(
  parameter int unsigned PDATA_WIDTH = PDATA_WIDTH_DEFAULT,
  parameter int unsigned FIFO_DEPTH  = 4,
  parameter int unsigned CAPTURE_DLY = 2
) (
  input  logic                   mclk_in,
  input  logic                   arst_in,
  input  logic                   lrck_in,
  input  logic [PDATA_WIDTH-1:0] pldata_in,
  input  logic [PDATA_WIDTH-1:0] prdata_in,
  output logic                   rx_valid_out,
  input  logic                   rx_ready_in,
  output logic [PDATA_WIDTH-1:0] rx_ldata_out,
  output logic [PDATA_WIDTH-1:0] rx_rdata_out,
  input  logic                   tx_valid_in,
  output logic                   tx_ready_out,
  input  logic [PDATA_WIDTH-1:0] tx_ldata_in,
  input  logic [PDATA_WIDTH-1:0] tx_rdata_in,
  output logic [PDATA_WIDTH-1:0] pldata_out,
  output logic [PDATA_WIDTH-1:0] prdata_out,
  output logic                   frame_out,
  input  logic                   clear_in,
  output logic                   rx_overflow_out,
  output logic                   tx_underflow_out
);

  localparam int unsigned FW = 2 * PDATA_WIDTH;

  logic                   r_lrck_q;
  logic                   r_frame;
  logic [CNT_W-1:0]       r_cap_cnt;
  logic [CNT_W-1:0]       w_cap_cnt_nxt;
  logic                   w_cap_write;
  logic                   w_fifo_full;
  logic                   w_fifo_empty;
  logic                   w_pop;
  logic [FW-1:0]          w_head;
  logic                   w_ovf_evt;
  logic                   w_unf_evt;
  logic                   w_tx_hs;
  logic                   r_hold_vld;
  logic [PDATA_WIDTH-1:0] r_hold_l;
  logic [PDATA_WIDTH-1:0] r_hold_r;
  logic [PDATA_WIDTH-1:0] r_pl;
  logic [PDATA_WIDTH-1:0] r_pr;
  logic                   r_ovf;
  logic                   r_unf;

  // LRCK falling-edge detect, registered into a one-cycle frame pulse.
  always_ff @(posedge mclk_in or posedge arst_in) begin
    if (arst_in) begin
      r_lrck_q <= 1'b0;
      r_frame  <= 1'b0;
    end else begin
      r_lrck_q <= lrck_in;
      r_frame  <= r_lrck_q & ~lrck_in;
    end
  end

  // Capture counter: zero means idle. The write happens in the cycle the
  // count steps from 1 to 0; a new frame pulse reloads and cancels it.
  always_comb begin
    w_cap_cnt_nxt = r_cap_cnt;
    w_cap_write   = 1'b0;
    if (r_frame) begin
      w_cap_cnt_nxt = CNT_W'(CAPTURE_DLY);
    end else if (r_cap_cnt != '0) begin
      w_cap_cnt_nxt = r_cap_cnt - 1'b1;
      w_cap_write   = (r_cap_cnt == CNT_W'(1));
    end
  end

  always_ff @(posedge mclk_in or posedge arst_in) begin
    if (arst_in) begin
      r_cap_cnt <= '0;
    end else begin
      r_cap_cnt <= w_cap_cnt_nxt;
    end
  end

  assign w_pop     = ~w_fifo_empty & rx_ready_in;
  assign w_ovf_evt = w_cap_write & w_fifo_full & ~w_pop;

  sample_fifo #(
    .WIDTH (FW),
    .DEPTH (FIFO_DEPTH)
  ) u_rx_fifo (
    .i_clk   (mclk_in),
    .i_rst   (arst_in),
    .i_push  (w_cap_write),
    .i_data  ({pldata_in, prdata_in}),
    .i_pop   (w_pop),
    .o_data  (w_head),
    .o_full  (w_fifo_full),
    .o_empty (w_fifo_empty)
  );

  assign rx_valid_out = ~w_fifo_empty;
  assign rx_ldata_out = w_head[FW-1:PDATA_WIDTH];
  assign rx_rdata_out = w_head[PDATA_WIDTH-1:0];

  // The frame pulse empties the holding register this cycle, so a new pair
  // may be accepted alongside the transfer to the drive registers.
  assign tx_ready_out = ~r_hold_vld | r_frame;
  assign w_tx_hs      = tx_valid_in & tx_ready_out;
  assign w_unf_evt    = r_frame & ~r_hold_vld;

  always_ff @(posedge mclk_in or posedge arst_in) begin
    if (arst_in) begin
      r_hold_vld <= 1'b0;
      r_hold_l   <= '0;
      r_hold_r   <= '0;
      r_pl       <= '0;
      r_pr       <= '0;
    end else begin
      if (r_frame && r_hold_vld) begin
        r_pl       <= r_hold_l;
        r_pr       <= r_hold_r;
        r_hold_vld <= 1'b0;
      end
      if (w_tx_hs) begin
        r_hold_l   <= tx_ldata_in;
        r_hold_r   <= tx_rdata_in;
        r_hold_vld <= 1'b1;
      end
    end
  end

  // Sticky flags: a set event outranks a same-cycle clear.
  always_ff @(posedge mclk_in or posedge arst_in) begin
    if (arst_in) begin
      r_ovf <= 1'b0;
      r_unf <= 1'b0;
    end else begin
      r_ovf <= w_ovf_evt | (r_ovf & ~clear_in);
      r_unf <= w_unf_evt | (r_unf & ~clear_in);
    end
  end

  assign pldata_out       = r_pl;
  assign prdata_out       = r_pr;
  assign frame_out        = r_frame;
  assign rx_overflow_out  = r_ovf;
  assign tx_underflow_out = r_unf;

endmodule

// File: tb/tb_i2s_sample_bridge.sv
module tb_i2s_sample_bridge;

  localparam int unsigned PW    = 32;
  localparam int unsigned DEPTH = 4;
  localparam int unsigned DLY   = 2;

  logic          mclk = 1'b0;
  logic          arst = 1'b1;
  logic          lrck = 1'b0;
  logic [PW-1:0] pl_in = '0, pr_in = '0;
  logic          rx_valid, rx_ready = 1'b0;
  logic [PW-1:0] rx_l, rx_r;
  logic          tx_valid = 1'b0, tx_ready;
  logic [PW-1:0] tx_l = '0, tx_r = '0;
  logic [PW-1:0] pl_out, pr_out;
  logic          frame, clr = 1'b0, ovf, unf;

  always #5 mclk = ~mclk;

  i2s_sample_bridge #(
    .PDATA_WIDTH (PW),
    .FIFO_DEPTH  (DEPTH),
    .CAPTURE_DLY (DLY)
  ) dut (
    .mclk_in          (mclk),
    .arst_in          (arst),
    .lrck_in          (lrck),
    .pldata_in        (pl_in),
    .prdata_in        (pr_in),
    .rx_valid_out     (rx_valid),
    .rx_ready_in      (rx_ready),
    .rx_ldata_out     (rx_l),
    .rx_rdata_out     (rx_r),
    .tx_valid_in      (tx_valid),
    .tx_ready_out     (tx_ready),
    .tx_ldata_in      (tx_l),
    .tx_rdata_in      (tx_r),
    .pldata_out       (pl_out),
    .prdata_out       (pr_out),
    .frame_out        (frame),
    .clear_in         (clr),
    .rx_overflow_out  (ovf),
    .tx_underflow_out (unf)
  );

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural reference model ----------------
  typedef struct packed {
    logic [31:0] l;
    logic [31:0] r;
  } pair_t;

  pair_t   m_q[$];
  pair_t   m_hold, m_drive;
  logic    m_hold_v, m_frame, m_last_lrck, m_ovf, m_unf;
  longint  m_cap_at;
  longint  cyc = 0;

  int unsigned g_P     = 256;
  int unsigned g_phase = 0;
  logic [31:0] g_pl    = '0;
  logic [31:0] g_pr    = '0;

  task automatic model_reset();
    m_q.delete();
    m_hold      = '0;
    m_drive     = '0;
    m_hold_v    = 1'b0;
    m_frame     = 1'b0;
    m_last_lrck = 1'b0;
    m_ovf       = 1'b0;
    m_unf       = 1'b0;
    m_cap_at    = -1;
  endtask

  task automatic check_outputs();
    chk("frame_out", {31'd0, frame}, {31'd0, m_frame});
    chk("rx_valid", {31'd0, rx_valid}, {31'd0, m_q.size() != 0});
    if (m_q.size() != 0) begin
      chk("rx_ldata", rx_l, m_q[0].l);
      chk("rx_rdata", rx_r, m_q[0].r);
    end
    chk("tx_ready", {31'd0, tx_ready}, {31'd0, !m_hold_v || m_frame});
    chk("pldata_out", pl_out, m_drive.l);
    chk("prdata_out", pr_out, m_drive.r);
    chk("rx_overflow", {31'd0, ovf}, {31'd0, m_ovf});
    chk("tx_underflow", {31'd0, unf}, {31'd0, m_unf});
  endtask

  // One mclk cycle: check present outputs, apply inputs, advance the model.
  task automatic step(input logic rdy, input logic txv, input logic [31:0] txl,
                      input logic [31:0] txr, input logic c);
    logic  hs, pop, wr, ovf_e, unf_e, lr;
    pair_t p;
    check_outputs();
    lr       = (g_phase < g_P / 2);
    lrck     = lr;
    rx_ready = rdy;
    tx_valid = txv;
    tx_l     = txl;
    tx_r     = txr;
    clr      = c;
    pl_in    = g_pl;
    pr_in    = g_pr;

    hs  = txv && (!m_hold_v || m_frame);
    pop = (m_q.size() != 0) && rdy;
    wr  = 1'b0;
    if (m_frame) m_cap_at = cyc + DLY;
    else if (m_cap_at == cyc) begin
      wr       = 1'b1;
      m_cap_at = -1;
    end
    ovf_e = 1'b0;
    if (pop) void'(m_q.pop_front());
    if (wr) begin
      if (m_q.size() < DEPTH) begin
        p.l = g_pl;
        p.r = g_pr;
        m_q.push_back(p);
      end else ovf_e = 1'b1;
    end
    unf_e = 1'b0;
    if (m_frame) begin
      if (m_hold_v) begin
        m_drive  = m_hold;
        m_hold_v = 1'b0;
      end else unf_e = 1'b1;
    end
    if (hs) begin
      m_hold.l = txl;
      m_hold.r = txr;
      m_hold_v = 1'b1;
    end
    m_ovf       = ovf_e || (m_ovf && !c);
    m_unf       = unf_e || (m_unf && !c);
    m_frame     = m_last_lrck && !lr;
    m_last_lrck = lr;
    cyc++;
    g_phase = (g_phase + 1) % g_P;
    @(negedge mclk);
  endtask

  task automatic idle_step(input logic rdy);
    step(rdy, 1'b0, '0, '0, 1'b0);
  endtask

  task automatic align(input logic rdy);
    while (g_phase != 0) idle_step(rdy);
  endtask

  task automatic wait_frame(input logic rdy);
    int unsigned n = 0;
    while (frame !== 1'b1 && n < 1000) begin
      idle_step(rdy);
      n++;
    end
    chk("frame_seen", {31'd0, frame}, 32'd1);
  endtask

  // Assert reset for n cycles while LRCK keeps running; check reset values.
  task automatic do_reset(input int unsigned n);
    arst     = 1'b1;
    tx_valid = 1'b0;
    clr      = 1'b0;
    #1;
    chk("rst_frame", {31'd0, frame}, 32'd0);
    chk("rst_rx_valid", {31'd0, rx_valid}, 32'd0);
    chk("rst_rx_ldata", rx_l, 32'd0);
    chk("rst_rx_rdata", rx_r, 32'd0);
    chk("rst_pldata", pl_out, 32'd0);
    chk("rst_prdata", pr_out, 32'd0);
    chk("rst_ovf", {31'd0, ovf}, 32'd0);
    chk("rst_unf", {31'd0, unf}, 32'd0);
    chk("rst_tx_ready", {31'd0, tx_ready}, 32'd1);
    model_reset();
    for (int unsigned i = 0; i < n; i++) begin
      @(negedge mclk);
      lrck    = (g_phase < g_P / 2);
      g_phase = (g_phase + 1) % g_P;
    end
    @(negedge mclk);
    arst = 1'b0;
  endtask

  // ---------------- frame-level vector table ----------------
  typedef struct {
    logic [31:0] pl, pr;
    logic        rdy, push, c;
    logic [31:0] txl, txr;
    logic        e_valid;
    logic [31:0] e_head_l, e_pl, e_pr;
    logic        e_ovf, e_unf;
  } row_t;

  row_t rows[9];

  function automatic row_t mk(input logic [31:0] pl, input logic [31:0] pr, input logic rdy,
                              input logic push, input logic c, input logic [31:0] txl,
                              input logic [31:0] txr, input logic ev, input logic [31:0] eh,
                              input logic [31:0] epl, input logic [31:0] epr,
                              input logic eo, input logic eu);
    row_t r;
    r.pl = pl; r.pr = pr; r.rdy = rdy; r.push = push; r.c = c; r.txl = txl; r.txr = txr;
    r.e_valid = ev; r.e_head_l = eh; r.e_pl = epl; r.e_pr = epr; r.e_ovf = eo; r.e_unf = eu;
    return r;
  endfunction

  task automatic run_row(input row_t r, input int unsigned idx);
    g_pl = r.pl;
    g_pr = r.pr;
    for (int unsigned ph = 0; ph < g_P; ph++) begin
      step(r.rdy, r.push && ph == 0, r.txl, r.txr, r.c && ph == 0);
    end
    chk($sformatf("row%0d_rx_valid", idx), {31'd0, rx_valid}, {31'd0, r.e_valid});
    if (r.e_valid) chk($sformatf("row%0d_rx_head", idx), rx_l, r.e_head_l);
    chk($sformatf("row%0d_pldata", idx), pl_out, r.e_pl);
    chk($sformatf("row%0d_prdata", idx), pr_out, r.e_pr);
    chk($sformatf("row%0d_ovf", idx), {31'd0, ovf}, {31'd0, r.e_ovf});
    chk($sformatf("row%0d_unf", idx), {31'd0, unf}, {31'd0, r.e_unf});
    chk($sformatf("row%0d_tx_ready", idx), {31'd0, tx_ready}, 32'd1);
  endtask

  initial begin
    int unsigned k;
    model_reset();
    rows[0] = mk(32'h11111111, 32'h22222222, 1, 0, 0, 0, 0,
                 0, 0, 32'h0, 32'h0, 0, 1);
    rows[1] = mk(32'h11111111, 32'h22222222, 1, 1, 1, 32'hAAAA0000, 32'h0000BBBB,
                 0, 0, 32'hAAAA0000, 32'h0000BBBB, 0, 0);
    rows[2] = mk(32'h11111111, 32'h22222222, 1, 0, 0, 0, 0,
                 0, 0, 32'hAAAA0000, 32'h0000BBBB, 0, 1);
    for (int unsigned i = 3; i <= 8; i++) begin
      rows[i] = mk(i, 32'h100 + i, 0, 1, i == 3, 32'hC0000000 + i, 32'hD0000000 + i,
                   1, 32'd3, 32'hC0000000 + i, 32'hD0000000 + i, i >= 7, 0);
    end

    @(negedge mclk);
    do_reset(3);

    // RX latency: valid appears 3 cycles after frame_out, for one cycle.
    g_pl = 32'h11111111;
    g_pr = 32'h22222222;
    wait_frame(1'b1);
    k = 0;
    while (rx_valid !== 1'b1 && k < 10) begin
      idle_step(1'b1);
      k++;
    end
    chk("rx_latency", k, 32'd3);
    chk("rx_first_l", rx_l, 32'h11111111);
    chk("rx_first_r", rx_r, 32'h22222222);
    idle_step(1'b1);
    chk("rx_pulse_end", {31'd0, rx_valid}, 32'd0);
    align(1'b1);

    for (int unsigned i = 0; i < 9; i++) run_row(rows[i], i);

    // Drain: first four frames retained in order, later two dropped.
    for (int unsigned i = 0; i < 4; i++) begin
      chk("drain_l", rx_l, 32'd3 + i);
      chk("drain_r", rx_r, 32'h103 + i);
      idle_step(1'b1);
    end
    chk("drain_empty", {31'd0, rx_valid}, 32'd0);
    step(1'b1, 1'b0, '0, '0, 1'b1);
    chk("ovf_cleared", {31'd0, ovf}, 32'd0);

    // TX push mid-frame: ready drops, returns in frame cycle, drive next cycle.
    step(1'b1, 1'b1, 32'hAAAA0000, 32'h0000BBBB, 1'b0);
    chk("tx_ready_low", {31'd0, tx_ready}, 32'd0);
    wait_frame(1'b1);
    chk("tx_ready_frame", {31'd0, tx_ready}, 32'd1);
    chk("tx_drive_old", pl_out, 32'hC0000008);
    idle_step(1'b1);
    chk("tx_drive_l", pl_out, 32'hAAAA0000);
    chk("tx_drive_r", pr_out, 32'h0000BBBB);
    chk("unf_before", {31'd0, unf}, 32'd0);

    // No push for a frame: drive holds, underflow set.
    wait_frame(1'b1);
    idle_step(1'b1);
    chk("unf_hold_l", pl_out, 32'hAAAA0000);
    chk("unf_set", {31'd0, unf}, 32'd1);

    // Handshake in the frame cycle while holding a pair.
    step(1'b1, 1'b1, 32'h12345678, 32'h9ABCDEF0, 1'b0);
    wait_frame(1'b1);
    step(1'b1, 1'b1, 32'h0BADF00D, 32'hFEEDC0DE, 1'b0);
    chk("hs_frame_drive", pl_out, 32'h12345678);
    chk("hs_frame_hold", {31'd0, tx_ready}, 32'd0);
    wait_frame(1'b1);
    idle_step(1'b1);
    chk("hs_frame_next", pl_out, 32'h0BADF00D);

    // Reset while a capture is pending: no write afterwards.
    wait_frame(1'b0);
    idle_step(1'b0);
    do_reset(2);
    for (int unsigned i = 0; i < 8; i++) idle_step(1'b0);
    chk("no_write_after_rst", {31'd0, rx_valid}, 32'd0);
    align(1'b0);

    // Randomised frames with varying period and traffic.
    for (int unsigned f = 0; f < 160; f++) begin
      int unsigned bias;
      g_P  = 2 * $urandom_range(1, 20);
      bias = $urandom_range(0, 4);
      if (f == 80) begin
        do_reset($urandom_range(1, 3));
        align(1'b0);
      end
      for (int unsigned ph = 0; ph < g_P; ph++) begin
        g_pl = $urandom;
        g_pr = $urandom;
        step($urandom_range(0, 3) < bias, $urandom_range(0, 1) == 1, $urandom, $urandom,
             $urandom_range(0, 31) == 0);
      end
    end
    idle_step(1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
